// File: rtl/xnor_lfsr_pkg.sv
// rtl/xnor_lfsr_pkg.sv - shared state type, mode constants and lockup helper for the XNOR LFSR engine
// Contents: lfsr_state_t (IDLE=0, GEN=1, SYNC=2, LOCKED=3), MODE_GEN/MODE_CHECK,
//           MISS_W (width of the consecutive-miss counter), is_lockup().
package xnor_lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GEN    = 2'd1,
        ST_SYNC   = 2'd2,
        ST_LOCKED = 2'd3
    } lfsr_state_t;

    localparam logic MODE_GEN   = 1'b0;
    localparam logic MODE_CHECK = 1'b1;

    // Wide enough for any loss threshold in 1..255.
    localparam int MISS_W = 8;

    // True when the low `width` bits of value are all ones: the XNOR lockup state.
    function automatic logic is_lockup(input logic [31:0] value, input int width);
        logic r_all;
        r_all = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i < width) && !value[i]) begin
                r_all = 1'b0;
            end
        end
        return r_all;
    endfunction

endpackage

// File: rtl/xnor_tap_reduce.sv
// rtl/xnor_tap_reduce.sv - masked XNOR feedback chain rooted on the logic-1 rail
// Ports: i_digit_supply [1] logic-1 rail (chain root), [0] logic-0 rail (pass-through identity)
//        i_lfsr         current register contents
//        o_fb           NOT(XOR of tapped bits) for an even number of taps
module xnor_tap_reduce #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic [1:0]       i_digit_supply,
    input  logic [WIDTH-1:0] i_lfsr,
    output logic             o_fb
);

    logic [WIDTH:0] w_chain;

    assign w_chain[0] = i_digit_supply[1];

    // Each tapped stage is an XNOR; starting from 1, an even number of XNOR
    // stages yields the inverted parity. Untapped stages XOR in the bit gated
    // by the logic-0 rail, so they pass the chain value through unchanged.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (TAPS[i]) begin : g_tap
            assign w_chain[i+1] = ~(w_chain[i] ^ i_lfsr[i]);
        end else begin : g_pass
            assign w_chain[i+1] = w_chain[i] ^ (i_lfsr[i] & i_digit_supply[0]);
        end
    end

    assign o_fb = w_chain[WIDTH];

endmodule

// File: rtl/xnor_lfsr_engine.sv
// rtl/xnor_lfsr_engine.sv - XNOR Fibonacci LFSR pattern generator / self-synchronising checker
// Ports: Clock, ResetN (async active-low), DigitSupply (rails), Mode (0 gen / 1 check, IDLE only),
//        Enable (step), Clear (sync return to IDLE), Load/LoadValue (preset), SerialIn (rx bit),
//        SerialOut (=Lfsr[0]), OutValid, Locked, ErrPulse, ErrCount (saturating), LockupFlag.
// Optional macro XNOR_LFSR_LOCKUP_RECOVER_EN: all-ones steps/loads are replaced by SEED
// and pulse LockupFlag; without it LockupFlag is constant 0.
module xnor_lfsr_engine
    import xnor_lfsr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
    parameter logic [WIDTH-1:0] SEED        = '0,
    parameter int               ERR_WIDTH   = 16,
    parameter int               LOSS_THRESH = 4
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic [1:0]           DigitSupply,
    input  logic                 Mode,
    input  logic                 Enable,
    input  logic                 Clear,
    input  logic                 Load,
    input  logic [WIDTH-1:0]     LoadValue,
    input  logic                 SerialIn,
    output logic                 SerialOut,
    output logic                 OutValid,
    output logic                 Locked,
    output logic                 ErrPulse,
    output logic [ERR_WIDTH-1:0] ErrCount,
    output logic                 LockupFlag
);

    localparam int SYNC_W = $clog2(WIDTH + 1);

    lfsr_state_t          r_state;
    logic [WIDTH-1:0]     r_lfsr;
    logic [ERR_WIDTH-1:0] r_err_cnt;
    logic [MISS_W-1:0]    r_miss_run;
    logic [SYNC_W-1:0]    r_sync_cnt;
    logic                 r_out_valid;
    logic                 r_err_pulse;
    logic                 r_lockup_flag;

    lfsr_state_t          w_state_nxt;
    lfsr_state_t          w_eff_state;
    logic [WIDTH-1:0]     w_lfsr_nxt;
    logic [WIDTH-1:0]     w_shift_lfsr;
    logic [ERR_WIDTH-1:0] w_err_nxt;
    logic [MISS_W-1:0]    w_miss_nxt;
    logic [MISS_W-1:0]    w_miss_inc;
    logic [SYNC_W-1:0]    w_sync_nxt;
    logic [SYNC_W-1:0]    w_sync_inc;
    logic                 w_valid_nxt;
    logic                 w_pulse_nxt;
    logic                 w_flag_nxt;
    logic                 w_fb;

    xnor_tap_reduce #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_tap_reduce (
        .i_digit_supply (DigitSupply),
        .i_lfsr         (r_lfsr),
        .o_fb           (w_fb)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state       <= ST_IDLE;
            r_lfsr        <= SEED;
            r_err_cnt     <= '0;
            r_miss_run    <= '0;
            r_sync_cnt    <= '0;
            r_out_valid   <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_lockup_flag <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lfsr        <= w_lfsr_nxt;
            r_err_cnt     <= w_err_nxt;
            r_miss_run    <= w_miss_nxt;
            r_sync_cnt    <= w_sync_nxt;
            r_out_valid   <= w_valid_nxt;
            r_err_pulse   <= w_pulse_nxt;
            r_lockup_flag <= w_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lfsr_nxt   = r_lfsr;
        w_err_nxt    = r_err_cnt;
        w_miss_nxt   = r_miss_run;
        w_sync_nxt   = r_sync_cnt;
        w_valid_nxt  = 1'b0;
        w_pulse_nxt  = 1'b0;
        w_flag_nxt   = 1'b0;
        w_shift_lfsr = {r_lfsr[WIDTH-2:0], w_fb};
        w_miss_inc   = r_miss_run + MISS_W'(1);
        w_sync_inc   = r_sync_cnt + SYNC_W'(1);

        // Mode only matters when leaving IDLE; afterwards the state decides.
        w_eff_state = r_state;
        if (r_state == ST_IDLE) begin
            w_eff_state = (Mode == MODE_CHECK) ? ST_SYNC : ST_GEN;
        end

        if (Clear) begin
            w_state_nxt = ST_IDLE;
            w_lfsr_nxt  = SEED;
            w_err_nxt   = '0;
            w_miss_nxt  = '0;
            w_sync_nxt  = '0;
        end else if (Load) begin
            w_lfsr_nxt = LoadValue;
`ifdef XNOR_LFSR_LOCKUP_RECOVER_EN
            if (is_lockup(32'(LoadValue), WIDTH)) begin
                w_lfsr_nxt = SEED;
                w_flag_nxt = 1'b1;
            end
`endif
            case (r_state)
                ST_IDLE: w_state_nxt = (Mode == MODE_CHECK) ? ST_LOCKED : ST_GEN;
                ST_SYNC: begin
                    w_state_nxt = ST_LOCKED;
                    w_sync_nxt  = '0;
                end
                default: ;
            endcase
        end else if (Enable) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = w_eff_state;
            case (w_eff_state)
                ST_SYNC: begin
                    w_lfsr_nxt = {r_lfsr[WIDTH-2:0], SerialIn};
                    w_sync_nxt = w_sync_inc;
                    if (w_sync_inc == SYNC_W'(WIDTH)) begin
                        w_state_nxt = ST_LOCKED;
                        w_sync_nxt  = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: keep generating locally and compare against the line.
                    w_lfsr_nxt = w_shift_lfsr;
                    if (SerialIn != w_fb) begin
                        w_pulse_nxt = 1'b1;
                        if (r_err_cnt != '1) begin
                            w_err_nxt = r_err_cnt + ERR_WIDTH'(1);
                        end
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == MISS_W'(LOSS_THRESH)) begin
                            w_state_nxt = ST_SYNC;
                            w_miss_nxt  = '0;
                            w_sync_nxt  = '0;
                        end
                    end else begin
                        w_miss_nxt = '0;
                    end
                end
                default: w_lfsr_nxt = w_shift_lfsr;
            endcase
`ifdef XNOR_LFSR_LOCKUP_RECOVER_EN
            if ((w_eff_state != ST_SYNC) && is_lockup(32'(r_lfsr), WIDTH)) begin
                w_lfsr_nxt = SEED;
                w_flag_nxt = 1'b1;
            end
`endif
        end
    end

    assign SerialOut  = r_lfsr[0];
    assign OutValid   = r_out_valid;
    assign Locked     = (r_state == ST_LOCKED);
    assign ErrPulse   = r_err_pulse;
    assign ErrCount   = r_err_cnt;
    assign LockupFlag = r_lockup_flag;

endmodule

// File: tb/tb_xnor_lfsr_engine.sv
// tb/tb_xnor_lfsr_engine.sv - self-checking bench for xnor_lfsr_engine (WIDTH=4, TAPS=1100)
module tb_xnor_lfsr_engine;

    localparam int         W      = 4;
    localparam logic [3:0] TAPS_P = 4'b1100;
    localparam logic [3:0] SEED_P = 4'b0000;
    localparam int         EW     = 4;
    localparam int         LT     = 4;
`ifdef XNOR_LFSR_LOCKUP_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    logic          Clock       = 1'b0;
    logic          ResetN      = 1'b0;
    logic [1:0]    DigitSupply = 2'b10;
    logic          Mode        = 1'b0;
    logic          Enable      = 1'b0;
    logic          Clear       = 1'b0;
    logic          Load        = 1'b0;
    logic [3:0]    LoadValue   = 4'h0;
    logic          SerialIn    = 1'b0;
    logic          SerialOut, OutValid, Locked, ErrPulse, LockupFlag;
    logic [EW-1:0] ErrCount;

    xnor_lfsr_engine #(
        .WIDTH(W), .TAPS(TAPS_P), .SEED(SEED_P), .ERR_WIDTH(EW), .LOSS_THRESH(LT)
    ) dut (
        .Clock(Clock), .ResetN(ResetN), .DigitSupply(DigitSupply), .Mode(Mode),
        .Enable(Enable), .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
        .SerialIn(SerialIn), .SerialOut(SerialOut), .OutValid(OutValid),
        .Locked(Locked), .ErrPulse(ErrPulse), .ErrCount(ErrCount), .LockupFlag(LockupFlag)
    );

    always #5 Clock = ~Clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Feedback from the rule: new bit is 1 when an even number of tapped bits are set.
    function automatic int fb_of(input int v);
        return (($countones(v & int'(TAPS_P)) % 2) == 0) ? 1 : 0;
    endfunction

    // Remote transmitter producing the reference serial stream.
    int tx;
    task automatic tx_step(output logic b);
        b  = 1'(fb_of(tx));
        tx = ((tx << 1) | int'(b)) & 15;
    endtask

    // Behavioural model: 0 idle, 1 gen, 2 sync, 3 locked.
    int m_lfsr, m_state, m_err, m_miss, m_sync;
    bit m_valid, m_pulse, m_flag;

    task automatic model_reset();
        m_lfsr = int'(SEED_P); m_state = 0; m_err = 0; m_miss = 0; m_sync = 0;
        m_valid = 0; m_pulse = 0; m_flag = 0;
    endtask

    task automatic model_clock();
        int eff, st, nb, old;
        m_valid = 0; m_pulse = 0; m_flag = 0;
        if (Clear) begin
            m_state = 0; m_lfsr = int'(SEED_P); m_err = 0; m_miss = 0; m_sync = 0;
        end else if (Load) begin
            m_lfsr = int'(LoadValue);
            if (RECOVER && LoadValue == 4'hF) begin m_lfsr = int'(SEED_P); m_flag = 1; end
            if (m_state == 0) m_state = Mode ? 3 : 1;
            else if (m_state == 2) begin m_state = 3; m_sync = 0; end
        end else if (Enable) begin
            m_valid = 1;
            eff = (m_state == 0) ? (Mode ? 2 : 1) : m_state;
            st  = eff;
            old = m_lfsr;
            if (eff == 2) begin
                nb = int'(SerialIn);
                m_sync++;
                if (m_sync == W) begin st = 3; m_sync = 0; end
            end else begin
                nb = fb_of(old);
                if (eff == 3) begin
                    if (int'(SerialIn) != nb) begin
                        m_pulse = 1;
                        if (m_err < (1 << EW) - 1) m_err++;
                        m_miss++;
                        if (m_miss == LT) begin st = 2; m_miss = 0; m_sync = 0; end
                    end else begin
                        m_miss = 0;
                    end
                end
            end
            m_lfsr = ((old << 1) | nb) & 15;
            if (RECOVER && eff != 2 && old == 15) begin m_lfsr = int'(SEED_P); m_flag = 1; end
            m_state = st;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        if (ResetN) model_clock();
        #1;
    endtask

    typedef struct {
        bit         en;
        logic [3:0] lfsr;
        bit         valid;
    } gen_row_t;
    gen_row_t gen_tab [0:16];

    initial begin
        logic b;
        bit   seen_f, err_seen;
        int   act, exp;

        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check("rst_lfsr", int'(dut.r_lfsr), 0);
        check("rst_outs", int'({SerialOut, OutValid, Locked, ErrPulse, LockupFlag}), 0);
        check("rst_errcount", int'(ErrCount), 0);
        ResetN = 1'b1;

        // Period table: hand-derived sequence of the 4-bit XNOR LFSR from 0000.
        gen_tab[0]  = '{1'b1, 4'h1, 1'b1};
        gen_tab[1]  = '{1'b1, 4'h3, 1'b1};
        gen_tab[2]  = '{1'b1, 4'h7, 1'b1};
        gen_tab[3]  = '{1'b1, 4'hE, 1'b1};
        gen_tab[4]  = '{1'b0, 4'hE, 1'b0};
        gen_tab[5]  = '{1'b1, 4'hD, 1'b1};
        gen_tab[6]  = '{1'b1, 4'hB, 1'b1};
        gen_tab[7]  = '{1'b1, 4'h6, 1'b1};
        gen_tab[8]  = '{1'b1, 4'hC, 1'b1};
        gen_tab[9]  = '{1'b1, 4'h9, 1'b1};
        gen_tab[10] = '{1'b1, 4'h2, 1'b1};
        gen_tab[11] = '{1'b1, 4'h5, 1'b1};
        gen_tab[12] = '{1'b1, 4'hA, 1'b1};
        gen_tab[13] = '{1'b1, 4'h4, 1'b1};
        gen_tab[14] = '{1'b1, 4'h8, 1'b1};
        gen_tab[15] = '{1'b1, 4'h0, 1'b1};
        gen_tab[16] = '{1'b0, 4'h0, 1'b0};
        Mode   = 1'b0;
        seen_f = 0;
        for (int i = 0; i < 17; i++) begin
            Enable = gen_tab[i].en;
            tick();
            check($sformatf("gen_lfsr[%0d]", i), int'(dut.r_lfsr), int'(gen_tab[i].lfsr));
            check($sformatf("gen_valid[%0d]", i), int'(OutValid), int'(gen_tab[i].valid));
            check($sformatf("gen_sout[%0d]", i), int'(SerialOut), int'(gen_tab[i].lfsr[0]));
            if (dut.r_lfsr == 4'hF) seen_f = 1;
        end
        check("gen_never_all_ones", int'(seen_f), 0);

        // Check lock from a fresh clear.
        Enable = 1'b0; Clear = 1'b1; tick(); Clear = 1'b0;
        Mode = 1'b1; Enable = 1'b1; tx = 0;
        for (int k = 1; k <= 4; k++) begin
            tx_step(b); SerialIn = b; tick();
            if (k == 1) check("sync_outvalid", int'(OutValid), 1);
            if (k == 3) check("lock_early", int'(Locked), 0);
            if (k == 4) check("lock_at_4", int'(Locked), 1);
        end
        err_seen = 0;
        for (int k = 0; k < 100; k++) begin
            tx_step(b); SerialIn = b; tick();
            if (ErrPulse) err_seen = 1;
        end
        check("lock_no_pulse", int'(err_seen), 0);
        check("lock_errcount", int'(ErrCount), 0);
        check("lock_held", int'(Locked), 1);

        // Single injected error.
        tx_step(b); SerialIn = ~b; tick();
        check("inj_pulse", int'(ErrPulse), 1);
        check("inj_errcount", int'(ErrCount), 1);
        check("inj_locked", int'(Locked), 1);
        tx_step(b); SerialIn = b; tick();
        check("inj_pulse_clear", int'(ErrPulse), 0);

        // Clear beats Enable, then relock and lose lock.
        Clear = 1'b1; tick(); Clear = 1'b0;
        check("clr_lfsr", int'(dut.r_lfsr), int'(SEED_P));
        check("clr_locked", int'(Locked), 0);
        check("clr_errcount", int'(ErrCount), 0);
        for (int k = 0; k < 4; k++) begin tx_step(b); SerialIn = b; tick(); end
        check("relock", int'(Locked), 1);
        for (int k = 1; k <= 4; k++) begin
            tx_step(b); SerialIn = ~b; tick();
            if (k == 3) check("loss_still_locked", int'(Locked), 1);
        end
        check("loss_unlocked", int'(Locked), 0);
        check("loss_errcount", int'(ErrCount), 4);
        for (int k = 1; k <= 4; k++) begin
            tx_step(b); SerialIn = b; tick();
            if (k == 3) check("resync_early", int'(Locked), 0);
        end
        check("resync_locked", int'(Locked), 1);

        // Saturation: 20 mismatches, never 4 in a row.
        for (int i = 0; i < 26; i++) begin
            tx_step(b); SerialIn = (i % 4 == 3) ? b : ~b; tick();
        end
        check("sat_errcount", int'(ErrCount), 15);
        check("sat_pulse", int'(ErrPulse), 1);
        check("sat_locked", int'(Locked), 1);

        // Load beats Enable; Mode ignored outside IDLE.
        Clear = 1'b1; tick(); Clear = 1'b0;
        Mode = 1'b0; Load = 1'b1; LoadValue = 4'h6; Enable = 1'b1; tick(); Load = 1'b0;
        check("load_lfsr", int'(dut.r_lfsr), 6);
        check("load_no_valid", int'(OutValid), 0);
        tick();
        check("load_step", int'(dut.r_lfsr), 4'hC);
        Mode = 1'b1; tick();
        check("mode_ignored_lfsr", int'(dut.r_lfsr), 4'h9);
        check("mode_ignored_lock", int'(Locked), 0);

        // Load in SYNC goes straight to LOCKED.
        Clear = 1'b1; tick(); Clear = 1'b0;
        Mode = 1'b1; SerialIn = 1'b0; tick(); tick();
        check("sync_not_locked", int'(Locked), 0);
        Load = 1'b1; LoadValue = 4'h5; tick(); Load = 1'b0;
        check("sync_load_locked", int'(Locked), 1);
        check("sync_load_lfsr", int'(dut.r_lfsr), 5);

        // All-ones lockup.
        Enable = 1'b0; Clear = 1'b1; tick(); Clear = 1'b0;
        Mode = 1'b0; Load = 1'b1; LoadValue = 4'hF; tick(); Load = 1'b0;
`ifdef XNOR_LFSR_LOCKUP_RECOVER_EN
        check("lockup_load_seed", int'(dut.r_lfsr), int'(SEED_P));
        check("lockup_flag", int'(LockupFlag), 1);
        Enable = 1'b1; tick();
        check("lockup_flag_once", int'(LockupFlag), 0);
        check("lockup_step", int'(dut.r_lfsr), 1);
`else
        check("lockup_load_ones", int'(dut.r_lfsr), 15);
        check("lockup_flag_zero", int'(LockupFlag), 0);
        Enable = 1'b1; tick(); tick();
        check("lockup_stays", int'(dut.r_lfsr), 15);
        check("lockup_flag_still_zero", int'(LockupFlag), 0);
`endif

        // Randomised run against the model.
        Enable = 1'b0; Clear = 1'b1; tick(); Clear = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            Clear     = ($urandom_range(0, 127) == 0);
            Load      = ($urandom_range(0, 39) == 0);
            LoadValue = 4'($urandom_range(0, 15));
            Enable    = ($urandom_range(0, 3) != 0);
            Mode      = 1'($urandom_range(0, 1));
            SerialIn  = 1'b0;
            if (Enable && !Clear && !Load) begin
                tx_step(b);
                SerialIn = b ^ ($urandom_range(0, 19) == 0);
            end
            tick();
            act = int'({dut.r_lfsr, SerialOut, OutValid, Locked, ErrPulse, LockupFlag, ErrCount});
            exp = ((m_lfsr & 15) << 9) | ((m_lfsr & 1) << 8) | (int'(m_valid) << 7)
                | ((m_state == 3 ? 1 : 0) << 6) | (int'(m_pulse) << 5) | (int'(m_flag) << 4)
                | (m_err & 15);
            check($sformatf("rand[%0d]", i), act, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
